fdc_phase_sequencer: RTL and testbench

Sequences the 82077AA command, execution and result phases for the FluxRipper FDC. It sits between the host register interface and the command executor. It consumes host data-register write and read strobes, and drives the MSR handshake bits (RQM, DIO, CB). It collects command bytes into a parameter buffer, hands a complete command to the executor, then buffers executor result bytes and returns them to the host.

---
 rtl/fdc_pkg.sv | 54 +++++
 rtl/fdc_phase_sequencer_if.sv | 32 +++
 rtl/fdc_result_buffer.sv | 59 +++++
 rtl/fdc_phase_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fdc_phase_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fdc_pkg.sv
// Shared 82077AA command definitions: opcodes, phase-sequencer states and command-length table.
package fdc_pkg;

  localparam logic [4:0] WRITE_DATA  = 5'h05;
  localparam logic [4:0] READ_DATA   = 5'h06;
  localparam logic [4:0] RECAL       = 5'h07;
  localparam logic [4:0] SENSE_INT   = 5'h08;
  localparam logic [4:0] READ_ID     = 5'h0A;
  localparam logic [4:0] FORMAT      = 5'h0D;
  localparam logic [4:0] DUMPREG     = 5'h0E;
  localparam logic [4:0] SEEK        = 5'h0F;
  localparam logic [4:0] SPECIFY     = 5'h03;
  localparam logic [4:0] SENSE_DRIVE = 5'h04;
  localparam logic [4:0] VERSION     = 5'h10;
  localparam logic [4:0] CONFIGURE   = 5'h13;

  localparam logic [7:0] ST0_INVALID = 8'h80;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StDispatch,
    StExec,
    StResult
  } fdc_state_e;

  // Total command length in bytes including the opcode byte; 0 marks an unknown opcode.
  function automatic logic [3:0] fdc_cmd_len(input logic [4:0] op);
    logic [3:0] len;
    case (op)
      READ_DATA:   len = 4'd9;
      WRITE_DATA:  len = 4'd9;
      READ_ID:     len = 4'd2;
      FORMAT:      len = 4'd6;
      RECAL:       len = 4'd2;
      SENSE_INT:   len = 4'd1;
      SPECIFY:     len = 4'd3;
      SENSE_DRIVE: len = 4'd2;
      SEEK:        len = 4'd3;
      VERSION:     len = 4'd1;
      CONFIGURE:   len = 4'd4;
      DUMPREG:     len = 4'd1;
      default:     len = 4'd0;
    endcase
    return len;
  endfunction

  // Commands whose completion never raises an interrupt.
  function automatic logic fdc_no_int(input logic [4:0] op);
    return (op == SENSE_INT) || (op == SENSE_DRIVE) || (op == VERSION) ||
           (op == SPECIFY) || (op == CONFIGURE) || (op == DUMPREG);
  endfunction

endpackage

// File: rtl/fdc_phase_sequencer_if.sv
// Host data-register and command-executor handshake bundle for the FDC phase sequencer.
interface fdc_phase_sequencer_if;

  logic       host_wr;
  logic [7:0] host_wr_data;
  logic       host_rd;
  logic [7:0] host_rd_data;
  logic       rqm;
  logic       dio;
  logic       busy;
  logic       exec_start;
  logic [4:0] opcode;
  logic [2:0] mtms;
  logic [3:0] param_addr;
  logic [7:0] param_data;
  logic       res_wr;
  logic [7:0] res_data;
  logic       exec_done;
  logic       int_req;
  logic       int_ack;

  modport slave (
    input  host_wr, host_wr_data, host_rd, param_addr, res_wr, res_data, exec_done, int_ack,
    output host_rd_data, rqm, dio, busy, exec_start, opcode, mtms, param_data, int_req
  );

  modport master (
    output host_wr, host_wr_data, host_rd, param_addr, res_wr, res_data, exec_done, int_ack,
    input  host_rd_data, rqm, dio, busy, exec_start, opcode, mtms, param_data, int_req
  );

endinterface

// File: rtl/fdc_result_buffer.sv
// Small circular FIFO holding executor result bytes until the host reads them back.
module fdc_result_buffer #(
  parameter int unsigned DEPTH = 10,
  localparam int unsigned IdxW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clr,
  input  logic            i_wr,
  input  logic [7:0]      i_wr_data,
  input  logic            i_rd,
  output logic [7:0]      o_rd_data,
  output logic [CntW-1:0] o_count,
  output logic            o_last
);

  logic [7:0]      r_mem [DEPTH];
  logic [IdxW-1:0] r_wr_idx;
  logic [IdxW-1:0] r_rd_idx;
  logic [CntW-1:0] r_count;
  logic            w_push;
  logic            w_pop;

  // Pushes into a full buffer are silently dropped.
  assign w_push = i_wr && (r_count < CntW'(DEPTH));
  assign w_pop  = i_rd && (r_count != '0);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_idx <= (r_wr_idx == IdxW'(DEPTH - 1)) ? '0 : r_wr_idx + 1'b1;
      end
      if (w_pop) begin
        r_rd_idx <= (r_rd_idx == IdxW'(DEPTH - 1)) ? '0 : r_rd_idx + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !(reset || i_clr)) begin
      r_mem[r_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_idx];
  assign o_count   = r_count;
  assign o_last    = (r_count == CntW'(1));

endmodule

// File: rtl/fdc_phase_sequencer.sv
// 82077AA command/execution/result phase sequencer: collects command bytes, dispatches to the
// executor, buffers result bytes for the host and drives the MSR handshake and interrupt.
module fdc_phase_sequencer
  import fdc_pkg::*;
#(
  parameter int unsigned MAX_CMD_BYTES = 9,
  parameter int unsigned MAX_RES_BYTES = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_soft_reset,
  fdc_phase_sequencer_if.slave bus
);

  localparam int unsigned ResCntW = $clog2(MAX_RES_BYTES + 1);

  fdc_state_e r_state;
  fdc_state_e w_state_nxt;

  logic [4:0]         r_opcode;
  logic [2:0]         r_mtms;
  logic [3:0]         r_len;
  logic [3:0]         r_cnt;
  logic [7:0]         r_param [MAX_CMD_BYTES];
  logic               r_int_req;

  logic               w_rst;
  logic [3:0]         w_cmd_len;
  logic               w_rqm;
  logic               w_dio;
  logic               w_busy;
  logic               w_exec_start;
  logic               w_latch_cmd;
  logic               w_param_wr;
  logic               w_res_push;
  logic [7:0]         w_res_push_data;
  logic               w_res_pop;
  logic               w_res_clr;
  logic               w_int_set;
  logic               w_int_clr;
  logic [7:0]         w_res_rd_data;
  logic [ResCntW-1:0] w_res_count;
  logic               w_res_last;

  assign w_rst     = reset || i_soft_reset;
  assign w_cmd_len = fdc_cmd_len(bus.host_wr_data[4:0]);

  always_comb begin
    w_state_nxt     = r_state;
    w_rqm           = 1'b1;
    w_dio           = 1'b0;
    w_busy          = 1'b0;
    w_exec_start    = 1'b0;
    w_latch_cmd     = 1'b0;
    w_param_wr      = 1'b0;
    w_res_push      = 1'b0;
    w_res_push_data = bus.res_data;
    w_res_pop       = 1'b0;
    w_res_clr       = 1'b0;
    w_int_set       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.host_wr) begin
          w_latch_cmd = 1'b1;
          if (w_cmd_len == 4'd0) begin
            // Unknown opcode answers with ST0 invalid without touching the executor.
            w_res_push      = 1'b1;
            w_res_push_data = ST0_INVALID;
            w_int_set       = !fdc_no_int(bus.host_wr_data[4:0]);
            w_state_nxt     = StResult;
          end else if (w_cmd_len == 4'd1) begin
            w_state_nxt = StDispatch;
          end else begin
            w_state_nxt = StCmd;
          end
        end
      end
      StCmd: begin
        w_busy = 1'b1;
        if (bus.host_wr) begin
          w_param_wr = 1'b1;
          if (r_cnt + 4'd1 == r_len) begin
            w_state_nxt = StDispatch;
          end
        end
      end
      StDispatch: begin
        w_rqm        = 1'b0;
        w_busy       = 1'b1;
        w_exec_start = 1'b1;
        w_state_nxt  = StExec;
      end
      StExec: begin
        w_rqm      = 1'b0;
        w_busy     = 1'b1;
        w_res_push = bus.res_wr;
        if (bus.exec_done) begin
          // A result byte pushed in the same cycle as exec_done still counts.
          w_state_nxt = ((w_res_count != '0) || bus.res_wr) ? StResult : StIdle;
          w_int_set   = !fdc_no_int(r_opcode);
        end
      end
      StResult: begin
        w_dio  = 1'b1;
        w_busy = 1'b1;
        if (bus.host_rd) begin
          w_res_pop = 1'b1;
          if (w_res_last) begin
            w_res_clr   = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign w_int_clr = bus.int_ack || ((r_state == StResult) && bus.host_rd && (r_opcode == SENSE_INT));

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state   <= StIdle;
      r_opcode  <= '0;
      r_mtms    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_int_req <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch_cmd) begin
        r_opcode <= bus.host_wr_data[4:0];
        r_mtms   <= bus.host_wr_data[7:5];
        r_len    <= w_cmd_len;
        r_cnt    <= 4'd1;
      end else if (w_param_wr) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_int_set) begin
        r_int_req <= 1'b1;
      end else if (w_int_clr) begin
        r_int_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_param_wr && !w_rst) begin
      r_param[r_cnt - 4'd1] <= bus.host_wr_data;
    end
  end

  fdc_result_buffer #(
    .DEPTH (MAX_RES_BYTES)
  ) u_result_buffer (
    .clk       (clk),
    .reset     (w_rst),
    .i_clr     (w_res_clr),
    .i_wr      (w_res_push),
    .i_wr_data (w_res_push_data),
    .i_rd      (w_res_pop),
    .o_rd_data (w_res_rd_data),
    .o_count   (w_res_count),
    .o_last    (w_res_last)
  );

  assign bus.rqm          = w_rqm;
  assign bus.dio          = w_dio;
  assign bus.busy         = w_busy;
  assign bus.exec_start   = w_exec_start;
  assign bus.opcode       = r_opcode;
  assign bus.mtms         = r_mtms;
  assign bus.int_req      = r_int_req;
  assign bus.host_rd_data = (r_state == StResult) ? w_res_rd_data : 8'h00;
  assign bus.param_data   = (32'(bus.param_addr) < MAX_CMD_BYTES) ? r_param[bus.param_addr]
                                                                  : 8'h00;

endmodule

// File: tb/tb_fdc_phase_sequencer.sv
// Directed plus randomized bench for the FDC phase sequencer, checked against a command-level model.
module tb_fdc_phase_sequencer;

  logic clk;
  logic reset;
  logic soft_reset;
  int   n_pass;
  int   n_total;
  bit   exp_int;

  fdc_phase_sequencer_if bus ();

  fdc_phase_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (soft_reset),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Command lengths taken straight from the 82077AA command set.
  function automatic int ref_len(input logic [4:0] op);
    case (op)
      5'h06, 5'h05: return 9;
      5'h0A, 5'h07, 5'h04: return 2;
      5'h0D: return 6;
      5'h08, 5'h10, 5'h0E: return 1;
      5'h03, 5'h0F: return 3;
      5'h13: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_raises_int(input logic [4:0] op);
    return !(op inside {5'h08, 5'h04, 5'h10, 5'h03, 5'h13, 5'h0E});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [7:0] b);
    bus.host_wr      = 1'b1;
    bus.host_wr_data = b;
    tick();
    bus.host_wr = 1'b0;
  endtask

  task automatic host_read();
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rqm"}, 32'(bus.rqm), 1);
    check({tag, "_dio"}, 32'(bus.dio), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // One full command: nres executor results; prm_fixed overrides random parameter bytes.
  task automatic run_cmd(input logic [7:0] cmd, input int nres, input bit stray_wr,
                         input logic [7:0] prm_fixed [$], input logic [7:0] res_fixed [$]);
    logic [4:0] op;
    int         len;
    logic [7:0] prm [$];
    logic [7:0] res [$];
    logic [7:0] b;
    bit         together;
    bit         ack_at_done;
    op  = cmd[4:0];
    len = ref_len(op);
    host_write(cmd);
    if (len == 0) begin
      res.push_back(8'h80);
      if (ref_raises_int(op)) exp_int = 1'b1;
      check("inv_no_exec_start", 32'(bus.exec_start), 0);
    end else begin
      check("busy_after_op", 32'(bus.busy), 1);
      for (int i = 1; i < len; i++) begin
        check("rqm_in_cmd", 32'(bus.rqm), 1);
        b = (prm_fixed.size() >= i) ? prm_fixed[i-1] : 8'($urandom);
        prm.push_back(b);
        host_write(b);
      end
      check("rqm_low_dispatch", 32'(bus.rqm), 0);
      check("exec_start_pulse", 32'(bus.exec_start), 1);
      check("opcode", 32'(bus.opcode), 32'(op));
      check("mtms", 32'(bus.mtms), 32'(cmd[7:5]));
      tick();
      check("exec_start_once", 32'(bus.exec_start), 0);
      check("rqm_low_exec", 32'(bus.rqm), 0);
      for (int i = 0; i < prm.size(); i++) begin
        bus.param_addr = 4'(i);
        #1;
        check("param_data", 32'(bus.param_data), 32'(prm[i]));
      end
      together    = 1'($urandom_range(0, 1));
      ack_at_done = 1'($urandom_range(0, 1));
      for (int k = 0; k < nres; k++) begin
        b = (res_fixed.size() > k) ? res_fixed[k] : 8'($urandom);
        if (res.size() < 10) res.push_back(b);
        bus.res_wr   = 1'b1;
        bus.res_data = b;
        if (k == nres - 1 && together) begin
          bus.exec_done = 1'b1;
          bus.int_ack   = ack_at_done;
        end
        tick();
        bus.res_wr    = 1'b0;
        bus.exec_done = 1'b0;
        bus.int_ack   = 1'b0;
      end
      if (nres == 0 || !together) begin
        bus.exec_done = 1'b1;
        bus.int_ack   = ack_at_done;
        tick();
        bus.exec_done = 1'b0;
        bus.int_ack   = 1'b0;
      end
      // A completion interrupt wins over an acknowledge in the same cycle.
      if (ref_raises_int(op)) exp_int = 1'b1;
      else if (ack_at_done) exp_int = 1'b0;
      check("rqm_after_done", 32'(bus.rqm), 1);
    end
    check("int_after_done", 32'(bus.int_req), 32'(exp_int));
    if (res.size() > 0) begin
      check("dio_result", 32'(bus.dio), 1);
      check("busy_result", 32'(bus.busy), 1);
      if (stray_wr) begin
        host_write(8'hA5);
        check("stray_wr_dio", 32'(bus.dio), 1);
        check("stray_wr_data", 32'(bus.host_rd_data), 32'(res[0]));
      end
      for (int i = 0; i < res.size(); i++) begin
        check("host_rd_data", 32'(bus.host_rd_data), 32'(res[i]));
        host_read();
        if (op == 5'h08) exp_int = 1'b0;
        check("int_during_read", 32'(bus.int_req), 32'(exp_int));
      end
    end
    check_idle("end_cmd");
  endtask

  initial begin
    logic [7:0] none [$];
    logic [7:0] ops [12];
    logic [7:0] cmd;
    logic [2:0] mt;
    int         nres;
    n_pass           = 0;
    n_total          = 0;
    exp_int          = 1'b0;
    ops              = '{8'h06, 8'h05, 8'h0A, 8'h0D, 8'h07, 8'h08,
                         8'h03, 8'h04, 8'h0F, 8'h10, 8'h13, 8'h0E};
    reset            = 1'b1;
    soft_reset       = 1'b0;
    bus.host_wr      = 1'b0;
    bus.host_wr_data = 8'h00;
    bus.host_rd      = 1'b0;
    bus.param_addr   = 4'd0;
    bus.res_wr       = 1'b0;
    bus.res_data     = 8'h00;
    bus.exec_done    = 1'b0;
    bus.int_ack      = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check_idle("reset");
    check("reset_exec_start", 32'(bus.exec_start), 0);
    check("reset_int_req", 32'(bus.int_req), 0);
    check("reset_opcode", 32'(bus.opcode), 0);
    check("reset_mtms", 32'(bus.mtms), 0);
    check("reset_rd_data", 32'(bus.host_rd_data), 0);

    // SPECIFY with fixed parameters and no results.
    run_cmd(8'h03, 0, 1'b0, '{8'hDF, 8'h02}, none);
    check("specify_no_int", 32'(bus.int_req), 0);

    // READ DATA with MT=0 MFM=1 SK=0, seven results, plus a stray write in RESULT.
    run_cmd(8'h46, 7, 1'b1, none, none);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    exp_int     = 1'b0;
    check("ack_clears_int", 32'(bus.int_req), 0);

    // SEEK then SENSE INTERRUPT.
    run_cmd(8'h0F, 0, 1'b0, '{8'h00, 8'h28}, none);
    check("seek_int", 32'(bus.int_req), 1);
    run_cmd(8'h08, 2, 1'b0, none, '{8'h20, 8'h28});

    // Invalid opcode.
    run_cmd(8'h1F, 0, 1'b0, none, none);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    exp_int     = 1'b0;

    // Stray read in IDLE.
    bus.host_rd = 1'b1;
    tick();
    bus.host_rd = 1'b0;
    check_idle("stray_rd");
    check("stray_rd_data", 32'(bus.host_rd_data), 0);

    // Soft reset partway through READ DATA, then a late exec_done.
    host_write(8'h46);
    for (int i = 0; i < 3; i++) host_write(8'(i + 1));
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check_idle("soft_reset");
    bus.exec_done = 1'b1;
    tick();
    bus.exec_done = 1'b0;
    check_idle("late_done");
    check("late_done_no_exec", 32'(bus.exec_start), 0);
    run_cmd(8'h10, 1, 1'b0, none, '{8'h90});

    // Full result buffer: extra pushes dropped.
    run_cmd(8'h0E, 12, 1'b0, none, none);

    // Randomized command stream.
    for (int n = 0; n < 30; n++) begin
      mt   = 3'($urandom_range(0, 7));
      cmd  = ops[$urandom_range(0, 11)];
      cmd  = {mt, cmd[4:0]};
      if ($urandom_range(0, 9) == 0) cmd = {mt, 5'h1F};
      nres = (cmd[4:0] inside {5'h07, 5'h0F, 5'h03}) ? 0 : $urandom_range(0, 11);
      run_cmd(cmd, nres, 1'($urandom_range(0, 1)), none, none);
      if ($urandom_range(0, 1) == 1) begin
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        exp_int     = 1'b0;
        check("rand_ack", 32'(bus.int_req), 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
